ahb_lite_fir_master: RTL and testbench

AHB-Lite bus master that drives the AHB-Lite FIR filter slave on behalf of a simple streaming producer. It accepts one 16-bit sample at a time over a valid/ready handshake and writes it to the filter's new-sample register. It then polls the filter's status register until the filter is idle, reads the result register, and presents the result on a one-cycle output strobe. It sits directly upstream of the filter slave, and its AHB outputs connect port-for-port to the slave's inputs.

---
 rtl/ahb_lite_fir_master.sv | 208 ++++++++++++++++++++
 tb/tb_ahb_lite_fir_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_fir_master.sv
// ahb_lite_fir_master
// AHB-Lite master that feeds one 16-bit sample at a time into the FIR filter
// slave. For each sample it writes the new-sample register, waits a few idle
// cycles, polls the status register until the filter is idle, reads the result
// and reports it on a one-cycle strobe.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   sample_in/valid/ready producer handshake (ready only in IDLE)
//   result_data/valid     filtered result and its one-cycle strobe
//   result_err/timeout    completion flags, valid with result_valid
//   busy                  transaction in progress
//   hsel..hwdata          AHB-Lite master outputs (zero-wait-state slave)
//   hrdata, hresp         AHB-Lite slave responses
module ahb_lite_fir_master #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_POLLS     = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] result_data,
    output logic        result_valid,
    output logic        result_err,
    output logic        result_timeout,
    output logic        busy,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MaxPolls   = 8'(MAX_POLLS);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StSettle,
        StPollAddr,
        StPollData,
        StRdAddr,
        StRdData
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [15:0] r_sample;
    logic [3:0]  r_settle;
    logic [7:0]  r_poll;
    logic [15:0] r_result_data;
    logic        r_result_valid;
    logic        r_result_err;
    logic        r_result_timeout;

    logic        w_capture;
    logic        w_load_settle;
    logic        w_clr_poll;
    logic        w_inc_poll;
    logic        w_finish;
    logic        w_fin_err;
    logic        w_fin_to;
    logic        w_load_res;
    logic [7:0]  w_poll_inc;
    logic        w_addr_phase;

    // Poll count including the poll whose data phase is in progress.
    assign w_poll_inc = (r_poll == MaxPolls) ? r_poll : r_poll + 8'd1;

    always_comb begin
        w_state_d     = r_state;
        w_capture     = 1'b0;
        w_load_settle = 1'b0;
        w_clr_poll    = 1'b0;
        w_inc_poll    = 1'b0;
        w_finish      = 1'b0;
        w_fin_err     = 1'b0;
        w_fin_to      = 1'b0;
        w_load_res    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (sample_valid) begin
                    w_capture = 1'b1;
                    w_state_d = StWrAddr;
                end
            end
            StWrAddr: w_state_d = StWrData;
            StWrData: begin
                if (hresp) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    w_load_settle = 1'b1;
                    w_state_d     = StSettle;
                end
            end
            StSettle: begin
                if (r_settle == 4'd0) begin
                    w_clr_poll = 1'b1;
                    w_state_d  = StPollAddr;
                end
            end
            StPollAddr: w_state_d = StPollData;
            StPollData: begin
                w_inc_poll = 1'b1;
                if (hresp) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                end else if (hrdata[0]) begin
                    // Busy flag takes precedence over the error flag.
                    if (w_poll_inc < MaxPolls) begin
                        w_state_d = StPollAddr;
                    end else begin
                        w_finish = 1'b1;
                        w_fin_to = 1'b1;
                    end
                end else if (hrdata[8]) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                end else begin
                    w_state_d = StRdAddr;
                end
            end
            StRdAddr: w_state_d = StRdData;
            StRdData: begin
                w_finish = 1'b1;
                if (hresp) begin
                    w_fin_err = 1'b1;
                end else begin
                    w_load_res = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
        if (w_finish) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state          <= StIdle;
            r_sample         <= 16'h0;
            r_settle         <= 4'h0;
            r_poll           <= 8'h0;
            r_result_data    <= 16'h0;
            r_result_valid   <= 1'b0;
            r_result_err     <= 1'b0;
            r_result_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_result_valid <= w_finish;
            if (w_capture) begin
                r_sample <= sample_in;
            end
            if (w_load_settle) begin
                r_settle <= SettleLoad;
            end else if (r_state == StSettle && r_settle != 4'd0) begin
                r_settle <= r_settle - 4'd1;
            end
            if (w_clr_poll) begin
                r_poll <= 8'h0;
            end else if (w_inc_poll) begin
                r_poll <= w_poll_inc;
            end
            if (w_finish) begin
                r_result_err     <= w_fin_err;
                r_result_timeout <= w_fin_to;
            end
            if (w_load_res) begin
                r_result_data <= hrdata;
            end
        end
    end

    assign w_addr_phase = (r_state == StWrAddr) || (r_state == StPollAddr) ||
                          (r_state == StRdAddr);

    always_comb begin
        haddr = 4'h0;
        unique case (r_state)
            StWrAddr:   haddr = 4'h4;
            StRdAddr:   haddr = 4'h2;
            default:    haddr = 4'h0;
        endcase
    end

    assign hsel           = w_addr_phase;
    assign hsize          = w_addr_phase;
    assign htrans         = w_addr_phase ? 2'b10 : 2'b00;
    assign hwrite         = (r_state == StWrAddr);
    assign hwdata         = (r_state == StWrData) ? r_sample : 16'h0;
    // Held low while reset is asserted, not just once the state register clears.
    assign sample_ready   = (r_state == StIdle) && n_rst;
    assign busy           = (r_state != StIdle);
    assign result_data    = r_result_data;
    assign result_valid   = r_result_valid;
    assign result_err     = r_result_err;
    assign result_timeout = r_result_timeout;

endmodule

// File: tb/tb_ahb_lite_fir_master.sv
module tb_ahb_lite_fir_master;

    localparam int S = 2;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] result_data;
    logic        result_valid;
    logic        result_err;
    logic        result_timeout;
    logic        busy;
    logic        hsel;
    logic [3:0]  haddr;
    logic        hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [15:0] hwdata;
    logic [15:0] hrdata = 16'h0;
    logic        hresp = 1'b0;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] prev_data = 16'h0;

    ahb_lite_fir_master #(
        .SETTLE_CYCLES(S),
        .MAX_POLLS(M)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .result_data(result_data),
        .result_valid(result_valid),
        .result_err(result_err),
        .result_timeout(result_timeout),
        .busy(busy),
        .hsel(hsel),
        .haddr(haddr),
        .hsize(hsize),
        .htrans(htrans),
        .hwrite(hwrite),
        .hwdata(hwdata),
        .hrdata(hrdata),
        .hresp(hresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag, input logic rdy);
        chk({tag, "_ready"}, 32'(sample_ready), 32'(rdy));
        chk({tag, "_rvalid"}, 32'(result_valid), 0);
        chk({tag, "_rerr"}, 32'(result_err), 0);
        chk({tag, "_rto"}, 32'(result_timeout), 0);
        chk({tag, "_rdata"}, 32'(result_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_bus"}, {hsel, haddr, hsize, htrans, hwrite, hwdata}, 0);
    endtask

    // One transaction with the bench acting as the filter slave. hresp_at:
    // 0 none, 1 write data phase, 2 first poll data phase, 3 result data phase.
    task automatic run_txn(input logic [15:0] smp, input logic [15:0] res, input int n_busy,
                           input bit ferr, input int hresp_at, input bit keep_valid);
        int          nwr = 0;
        int          npoll = 0;
        int          nrd = 0;
        int          pidx = 0;
        int          lat = -1;
        int          acc;
        bit          prev_addr = 0;
        bit          prev_wr = 0;
        bit          seq_bad = 0;
        logic [15:0] wd_seen = 16'hxxxx;
        logic [15:0] rv_data = 16'hxxxx;
        logic        rv_err = 1'bx;
        logic        rv_to = 1'bx;
        int          e_polls;
        bit          e_rd;
        bit          e_err;
        bit          e_to;
        int          e_lat;
        logic [15:0] e_data;

        // Expected outcome from the protocol rules alone.
        if (hresp_at == 1) begin
            e_polls = 0; e_rd = 0; e_err = 1; e_to = 0; e_lat = 2;
        end else if (hresp_at == 2) begin
            e_polls = 1; e_rd = 0; e_err = 1; e_to = 0; e_lat = 2 + S + 2;
        end else if (n_busy >= M) begin
            e_polls = M; e_rd = 0; e_err = 0; e_to = 1; e_lat = 2 + S + 2 * M;
        end else begin
            e_polls = n_busy + 1;
            e_rd    = !ferr;
            e_err   = ferr || (hresp_at == 3);
            e_to    = 0;
            e_lat   = 2 + S + 2 * e_polls + (e_rd ? 2 : 0);
        end
        e_data = (e_rd && hresp_at != 3) ? res : prev_data;

        sample_in    = smp;
        sample_valid = 1'b1;
        hresp        = 1'b0;
        chk("ready_at_accept", 32'(sample_ready), 1);
        acc = cyc;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!keep_valid) sample_valid = 1'b0;
            if (k == 0) begin
                chk("wr_addr_next", {hsel, htrans, haddr, hwrite, hsize},
                    {1'b1, 2'b10, 4'h4, 1'b1, 1'b1});
            end
            if (hsel && htrans == 2'b10) begin
                if (prev_addr) seq_bad = 1;
                hresp   = 1'b0;
                prev_wr = hwrite;
                if (hwrite) begin
                    nwr++;
                    if (hresp_at == 1) hresp = 1'b1;
                end else if (haddr == 4'h0) begin
                    npoll++;
                    hrdata = (pidx < n_busy) ? 16'h0001 : (ferr ? 16'h0100 : 16'h0000);
                    pidx++;
                    if (hresp_at == 2 && npoll == 1) hresp = 1'b1;
                end else if (haddr == 4'h2) begin
                    nrd++;
                    hrdata = res;
                    if (hresp_at == 3) hresp = 1'b1;
                end
                prev_addr = 1;
            end else begin
                if (prev_addr && prev_wr) wd_seen = hwdata;
                if (!prev_addr) hresp = 1'b0;
                prev_addr = 0;
                prev_wr   = 0;
            end
            if (result_valid) begin
                lat     = cyc - acc - 1;
                rv_data = result_data;
                rv_err  = result_err;
                rv_to   = result_timeout;
                break;
            end
        end
        hresp = 1'b0;
        chk("rv_latency", 32'(lat), 32'(e_lat));
        chk("rv_data", 32'(rv_data), 32'(e_data));
        chk("rv_err", 32'(rv_err), 32'(e_err));
        chk("rv_timeout", 32'(rv_to), 32'(e_to));
        chk("n_writes", 32'(nwr), 1);
        chk("n_polls", 32'(npoll), 32'(e_polls));
        chk("n_reads", 32'(nrd), 32'(e_rd ? 1 : 0));
        chk("hwdata", 32'(wd_seen), 32'(smp));
        chk("bus_seq", 32'(seq_bad), 0);
        chk("rv_state_idle", {31'h0, busy}, 0);
        prev_data = e_data;
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset", 1'b0);
        n_rst = 1'b1;
        #1;
        chk_reset_outputs("after_reset", 1'b1);
        @(negedge clk);

        // Directed cases
        run_txn(16'h1234, 16'h00AB, 0, 0, 0, 0);   // single sample
        run_txn(16'h5555, 16'h0F0F, 3, 0, 0, 0);   // busy polling
        run_txn(16'h2222, 16'hDEAD, 0, 1, 0, 0);   // filter error
        run_txn(16'h3333, 16'hBEEF, 9, 0, 0, 0);   // timeout
        run_txn(16'h4444, 16'hCAFE, 0, 0, 1, 0);   // hresp on write
        run_txn(16'h6666, 16'hCAFE, 2, 0, 2, 0);   // hresp on poll
        run_txn(16'h7777, 16'h1111, 1, 0, 3, 0);   // hresp on result read
        run_txn(16'h8888, 16'h0A0A, 0, 0, 0, 0);
        // Back-to-back with sample_valid held high
        run_txn(16'h9001, 16'h0101, 0, 0, 0, 1);
        run_txn(16'h9002, 16'h0202, 2, 0, 0, 1);
        run_txn(16'h9003, 16'h0303, 0, 0, 0, 0);

        // Reset during POLL_DATA
        @(negedge clk);
        sample_in    = 16'hABCD;
        sample_valid = 1'b1;
        found        = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (hsel && htrans == 2'b10 && haddr == 4'h0 && !hwrite) begin
                hrdata = 16'h0001;
                found  = 1;
                break;
            end
        end
        chk("poll_reached", 32'(found), 1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset", 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_reset_no_rv", 32'(result_valid), 0);
        end
        n_rst = 1'b1;
        #1;
        chk_reset_outputs("mid_release", 1'b1);
        prev_data = 16'h0;
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_no_rv", 32'(result_valid), 0);
        end

        // Randomised transactions
        for (int i = 0; i < 25; i++) begin
            int h;
            h = int'($urandom_range(0, 7));
            run_txn(16'($urandom), 16'($urandom), int'($urandom_range(0, 5)),
                    ($urandom_range(0, 3) == 0), (h > 3) ? 0 : h, ($urandom_range(0, 1) == 1));
        end
        sample_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
